snitch_tcdm_amo_bank: RTL



---
 rtl/snitch_tcdm_amo_bank.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/snitch_tcdm_amo_bank.sv
// Per-bank TCDM adapter: request channel to single-port SRAM strobes with
// 1-cycle response latency, plus in-bank read-modify-write for RISC-V atomics.

package snitch_tcdm_amo_bank_pkg;

  typedef enum logic [3:0] {
    AMONone = 4'h0,
    AMOSwap = 4'h1,
    AMOAdd  = 4'h2,
    AMOAnd  = 4'h3,
    AMOOr   = 4'h4,
    AMOXor  = 4'h5,
    AMOMax  = 4'h6,
    AMOMaxu = 4'h7,
    AMOMin  = 4'h8,
    AMOMinu = 4'h9,
    AMOLR   = 4'hA,
    AMOSC   = 4'hB
  } amo_op_e;

  // Default request/response payloads for a 10-bit, 32-bit bank.
  typedef struct packed {
    logic [9:0]  addr;
    logic        write;
    amo_op_e     amo;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        user;
  } tcdm_req_chan_t;

  typedef struct packed {
    logic           q_valid;
    tcdm_req_chan_t q;
  } tcdm_req_t;

  typedef struct packed {
    logic [31:0] data;
  } tcdm_rsp_chan_t;

  typedef struct packed {
    logic           q_ready;
    tcdm_rsp_chan_t p;
  } tcdm_rsp_t;

endpackage

module snitch_tcdm_amo_bank
  import snitch_tcdm_amo_bank_pkg::*;
#(
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 32,
  parameter type mem_req_t = tcdm_req_t,
  parameter type mem_rsp_t = tcdm_rsp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  mem_req_t               req_i,
  output mem_rsp_t               rsp_o,
  output logic                   sram_req_o,
  output logic                   sram_we_o,
  output logic [AddrWidth-1:0]   sram_addr_o,
  output logic [DataWidth-1:0]   sram_wdata_o,
  output logic [DataWidth/8-1:0] sram_be_o,
  input  logic [DataWidth-1:0]   sram_rdata_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned HalfWidth = DataWidth / 2;
  localparam bit          HalfOps   = (DataWidth == 64);
  localparam logic [StrbWidth-1:0] StrbLo = StrbWidth'({(StrbWidth/2){1'b1}});
  localparam logic [StrbWidth-1:0] StrbHi = ~StrbLo;

  typedef enum logic {IDLE, AMO_WB} state_e;

  state_e                 state_q, state_d;
  amo_op_e                amo_q, amo_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [DataWidth-1:0]   operand_q, operand_d;
  logic [StrbWidth-1:0]   strb_q, strb_d;
  logic                   sc_zero_q, sc_zero_d;

  logic                   q_ready;
  logic                   is_rmw;
  logic                   strb_ok;
  logic                   lane_lo, lane_hi;
  logic [DataWidth-1:0]   a_n, b_n, r_n, amo_wdata;
  logic                   unused_user;

  assign unused_user = ^req_i.q.user;

  // Classify the incoming op as an in-bank read-modify-write.
  always_comb begin
    is_rmw = 1'b0;
    case (req_i.q.amo)
      AMOSwap, AMOAdd, AMOAnd, AMOOr, AMOXor,
      AMOMax, AMOMaxu, AMOMin, AMOMinu: is_rmw = 1'b1;
      default: is_rmw = 1'b0;
    endcase
  end

  assign strb_ok = (req_i.q.strb == '1) ||
                   (HalfOps && ((req_i.q.strb == StrbLo) || (req_i.q.strb == StrbHi)));

  // AMO ALU: half-lane ops are shifted to the top of the word so that
  // wrap-around and signed compares behave at lane width.
  always_comb begin
    lane_lo = HalfOps && (strb_q == StrbLo);
    lane_hi = HalfOps && (strb_q == StrbHi);
    a_n     = sram_rdata_i;
    b_n     = operand_q;
    if (lane_lo) begin
      a_n = {sram_rdata_i[HalfWidth-1:0], {HalfWidth{1'b0}}};
      b_n = {operand_q[HalfWidth-1:0], {HalfWidth{1'b0}}};
    end else if (lane_hi) begin
      a_n = {sram_rdata_i[DataWidth-1:HalfWidth], {HalfWidth{1'b0}}};
      b_n = {operand_q[DataWidth-1:HalfWidth], {HalfWidth{1'b0}}};
    end
    case (amo_q)
      AMOAdd:  r_n = a_n + b_n;
      AMOAnd:  r_n = a_n & b_n;
      AMOOr:   r_n = a_n | b_n;
      AMOXor:  r_n = a_n ^ b_n;
      AMOMax:  r_n = ($signed(a_n) > $signed(b_n)) ? a_n : b_n;
      AMOMaxu: r_n = (a_n > b_n) ? a_n : b_n;
      AMOMin:  r_n = ($signed(a_n) < $signed(b_n)) ? a_n : b_n;
      AMOMinu: r_n = (a_n < b_n) ? a_n : b_n;
      default: r_n = b_n;
    endcase
    if (lane_lo) begin
      amo_wdata = {sram_rdata_i[DataWidth-1:HalfWidth], r_n[DataWidth-1:HalfWidth]};
    end else if (lane_hi) begin
      amo_wdata = {r_n[DataWidth-1:HalfWidth], sram_rdata_i[HalfWidth-1:0]};
    end else begin
      amo_wdata = r_n;
    end
  end

  // Next-state and SRAM strobe generation.
  always_comb begin
    state_d      = state_q;
    amo_d        = amo_q;
    addr_d       = addr_q;
    operand_d    = operand_q;
    strb_d       = strb_q;
    sc_zero_d    = 1'b0;
    q_ready      = 1'b0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = req_i.q.addr;
    sram_wdata_o = req_i.q.data;
    sram_be_o    = req_i.q.strb;
    if (rst_ni) begin
      case (state_q)
        IDLE: begin
          q_ready = 1'b1;
          if (req_i.q_valid) begin
            sram_req_o = 1'b1;
            if (is_rmw) begin
              amo_d     = amo_op_e'(req_i.q.amo);
              addr_d    = req_i.q.addr;
              operand_d = req_i.q.data;
              strb_d    = req_i.q.strb;
              state_d   = AMO_WB;
            end else if (req_i.q.amo == AMOSC) begin
              sram_we_o = 1'b1;
              sc_zero_d = 1'b1;
            end else if (req_i.q.amo == AMONone) begin
              sram_we_o = req_i.q.write;
            end
          end
        end
        AMO_WB: begin
          sram_req_o   = 1'b1;
          sram_we_o    = 1'b1;
          sram_addr_o  = addr_q;
          sram_wdata_o = amo_wdata;
          sram_be_o    = strb_q;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Response: SRAM read data one cycle after acceptance, forced to 0 after SC.
  always_comb begin
    rsp_o         = '0;
    rsp_o.q_ready = q_ready;
    rsp_o.p.data  = sc_zero_q ? '0 : sram_rdata_i;
  end

  // State and AMO latch registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      amo_q     <= AMONone;
      addr_q    <= '0;
      operand_q <= '0;
      strb_q    <= '0;
      sc_zero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      amo_q     <= amo_d;
      addr_q    <= addr_d;
      operand_q <= operand_d;
      strb_q    <= strb_d;
      sc_zero_q <= sc_zero_d;
    end
  end

  // Only full-word or (64-bit) half-word strobes are meaningful for RMW AMOs.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   (req_i.q_valid && q_ready && is_rmw) |-> strb_ok)
    else $error("snitch_tcdm_amo_bank: illegal AMO strobe pattern");

endmodule
